// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state enum, ALU mode codes and command width for the ALU command sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  localparam logic [2:0] MODE_ADD  = 3'd0;
  localparam logic [2:0] MODE_SUB  = 3'd1;
  localparam logic [2:0] MODE_MUL  = 3'd2;
  localparam logic [2:0] MODE_DIV  = 3'd3;
  localparam logic [2:0] MODE_AND  = 3'd4;
  localparam logic [2:0] MODE_OR   = 3'd5;
  localparam logic [2:0] MODE_NOR  = 3'd6;
  localparam logic [2:0] MODE_NAND = 3'd7;
  localparam int CMD_W = 19;
endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous power-of-two FIFO with registered count and async active-low reset
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered ALU command issuer with result handshake; WAIT timeout enabled by ALU_SEQ_TIMEOUT_EN
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [2:0]  in_mode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_mode,
  input  logic [7:0]  alu_op1,
  input  logic [7:0]  alu_op2,
  input  logic [15:0] alu_op3,
  input  logic        alu_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  res_p1,
  output logic [7:0]  res_p2,
  output logic [15:0] res_p3,
  output logic [2:0]  res_mode,
  output logic        res_err,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + MIN_WAIT + 2);
  state_t state;
  logic [CW-1:0] cnt;
  logic [CMD_W-1:0] head;
  logic full, empty, qual, tmo, fin;
  assign in_ready = !full;
  assign busy = state != IDLE || !empty;
  assign qual = alu_done && (int'(cnt) + 1 >= MIN_WAIT);
  assign fin = state == WAIT && (qual || tmo);
  alu_seq_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(in_valid && in_ready),
    .pop(state == IDLE),
    .din({in_mode, in_a, in_b}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
`ifdef ALU_SEQ_TIMEOUT_EN
  assign tmo = !qual && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) res_err <= 1'b0;
    else if (fin) res_err <= !qual;
`else
  assign tmo = 1'b0;
  assign res_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_mode <= MODE_ADD;
      out_valid <= 1'b0;
      res_p1 <= '0;
      res_p2 <= '0;
      res_p3 <= '0;
      res_mode <= MODE_ADD;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          {alu_mode, alu_a, alu_b} <= head;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= &cnt ? cnt : cnt + CW'(1);
          if (fin) begin
            res_p1 <= qual ? alu_op1 : '0;
            res_p2 <= qual ? alu_op2 : '0;
            res_p3 <= qual ? alu_op3 : '0;
            res_mode <= alu_mode;
            out_valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized scoreboard bench with a behavioural ALU for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;
  localparam int TIMEOUT = 64;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, alu_done, out_valid, out_ready, res_err, busy;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_op1, alu_op2, res_p1, res_p2;
  logic [2:0] in_mode, alu_mode, res_mode;
  logic [15:0] alu_op3, res_p3;
  int total = 0, bad = 0, nres = 0, lat_max = 0, pend = 0;
  bit done_off = 0, expect_tmo = 0;
  logic [7:0] la = '0, lb = '0;
  logic [2:0] lm = '0;
  logic [35:0] sb [$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .MIN_WAIT(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3), .alu_done(alu_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_p1(res_p1), .res_p2(res_p2), .res_p3(res_p3), .res_mode(res_mode),
    .res_err(res_err), .busy(busy)
  );

  function automatic logic [31:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    logic [7:0] p1, p2;
    logic [15:0] p3;
    p1 = '0;
    p2 = '0;
    p3 = '0;
    case (m)
      MODE_ADD: {p2[0], p1} = {1'b0, a} + {1'b0, b};
      MODE_SUB: begin p1 = a - b; p2 = {7'd0, a < b}; end
      MODE_MUL: p3 = 16'(a) * 16'(b);
      MODE_DIV: begin p1 = b == 0 ? 8'hff : a / b; p2 = b == 0 ? a : a % b; end
      MODE_AND: p1 = a & b;
      MODE_OR:  p1 = a | b;
      MODE_NOR: p1 = ~(a | b);
      default:  p1 = ~(a & b);
    endcase
    return {p3, p2, p1};
  endfunction

  // behavioural ALU: registered results, done drops for a random latency after an input change
  initial begin
    alu_done = 1'b0;
    alu_op1 = '0;
    alu_op2 = '0;
    alu_op3 = '0;
  end
  always @(posedge clk) begin
    if ({alu_a, alu_b, alu_mode} != {la, lb, lm}) begin
      la = alu_a;
      lb = alu_b;
      lm = alu_mode;
      pend = lat_max == 0 ? 0 : int'($urandom_range(lat_max, 0));
    end
    if (pend > 0) begin
      pend--;
      alu_done <= 1'b0;
    end else begin
      {alu_op3, alu_op2, alu_op1} <= alu_fn(la, lb, lm);
      alu_done <= !done_off;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else begin
      if (in_valid && in_ready)
        sb.push_back(expect_tmo ? {1'b1, in_mode, 32'd0} : {1'b0, in_mode, alu_fn(in_a, in_b, in_mode)});
      if (out_valid && out_ready) begin
        nres++;
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else chk("result", {res_err, res_mode, res_p3, res_p2, res_p1}, sb.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
    int n;
    in_a = a;
    in_b = b;
    in_mode = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("result_arrives", out_valid, 1);
  endtask

  task automatic drain1();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drain1_clear", out_valid, 0);
  endtask

  initial begin
    int n, n0;
    logic [2:0] m;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_mode = '0;
    out_ready = 1'b0;
    step(3);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_a, alu_b, alu_mode}, 0);
    chk("rst_res", {res_p1, res_p2, res_p3, res_mode, res_err}, 0);
    rst_n = 1'b1;
    step(2);

    // exact latency: accept at edge k, pop at k+1, capture at k+1+MIN_WAIT
    in_a = 8'd200;
    in_b = 8'd100;
    in_mode = MODE_ADD;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_k_busy", busy, 1);
    step();
    chk("lat_issue", {alu_a, alu_b, alu_mode}, {8'd200, 8'd100, MODE_ADD});
    chk("lat_k1_ov", out_valid, 0);
    step();
    chk("lat_k2_ov", out_valid, 0);
    step();
    chk("lat_k3_ov", out_valid, 1);
    chk("add_p1", res_p1, 44);
    chk("add_p2", res_p2, 1);
    chk("add_err", res_err, 0);
    drain1();
    step();
    chk("alu_hold", {alu_a, alu_b}, {8'd200, 8'd100});
    chk("idle_busy", busy, 0);

    run_one(8'd15, 8'd17, MODE_MUL);
    chk("mul_p3", res_p3, 16'd255);
    chk("mul_p1", res_p1, 0);
    drain1();
    run_one(8'd100, 8'd7, MODE_DIV);
    chk("div_p1", res_p1, 14);
    chk("div_p2", res_p2, 2);
    drain1();

    // back-pressure: one in flight plus four queued, sixth push refused
    n0 = nres;
    for (int i = 0; i < 6; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      in_mode = 3'($urandom);
      in_valid = 1'b1;
      chk($sformatf("bp_in_ready%0d", i), in_ready, i < 5);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      step();
      n++;
    end
    chk("bp_drained", sb.size(), 0);
    chk("bp_count", nres - n0, 5);

    // randomized traffic with random ALU latency and consumer stalls
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      in_a = 8'($urandom);
      in_b = 8'($urandom_range(3, 0) == 0 ? 0 : $urandom);
      in_mode = 3'($urandom);
      in_valid = 1'($urandom);
      out_ready = $urandom_range(3, 0) != 0;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      step();
      n++;
    end
    chk("rand_drained", sb.size(), 0);
    step(2);
    chk("rand_idle", busy, 0);

    // reset while waiting with two commands queued
    lat_max = 0;
    done_off = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 8'(i + 1);
      in_b = 8'(i + 9);
      in_mode = MODE_SUB;
      step();
    end
    in_valid = 1'b0;
    step(2);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_ov", out_valid, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    done_off = 1'b0;
    out_ready = 1'b1;
    n0 = nres;
    step(20);
    chk("midrst_no_result", nres - n0, 0);
    chk("midrst_idle", busy, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    done_off = 1'b1;
    out_ready = 1'b0;
    m = 3'($urandom);
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    in_mode = m;
    expect_tmo = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    expect_tmo = 1'b0;
    step();
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk("tmo_latency", n, TIMEOUT);
    chk("tmo_err", res_err, 1);
    chk("tmo_res", {res_p1, res_p2, res_p3}, 0);
    chk("tmo_mode", res_mode, m);
    drain1();
    done_off = 1'b0;
    step(3);
`else
    m = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end
endmodule
